// File: rtl/ble_pkg.sv
// ble_pkg -- shared types and helpers for the configurable LUT basic logic element.
//
// Contents:
//   out_mode_e   : output select of the element (COMB = raw LUT, REG = flip-flop)
//   cfg_width()  : configuration chain length for a K-input element (2**K + 2)
//   mode_ofs()   : bit position of the mode bit inside the config register
//   init_ofs()   : bit position of the FF init bit inside the config register
//   TT_LSB       : bit position of tt[0]; the truth table fills cfg_reg[2**K-1:0]
//   MODE_OFS/INIT_OFS : the same offsets for the default K=4 element (CFG_W = 18)
package ble_pkg;

    typedef enum logic {
        COMB = 1'b0,
        REG  = 1'b1
    } out_mode_e;

    function automatic int cfg_width(input int k);
        return (1 << k) + 2;
    endfunction

    function automatic int mode_ofs(input int k);
        return cfg_width(k) - 1;
    endfunction

    function automatic int init_ofs(input int k);
        return cfg_width(k) - 2;
    endfunction

    localparam int K_DEF     = 4;
    localparam int CFG_W_DEF = cfg_width(K_DEF);
    localparam int MODE_OFS  = CFG_W_DEF - 1;
    localparam int INIT_OFS  = CFG_W_DEF - 2;
    localparam int TT_LSB    = 0;

endpackage

// File: rtl/cfg_lut_ble_if.sv
// cfg_lut_ble_if -- configuration and logic signals of one LUT basic logic element.
//
// Signals:
//   cfg_en    : shift one config bit per cycle while high
//   cfg_in    : serial config data in
//   cfg_clr   : synchronous clear of config register and bit counter
//   cfg_out   : serial config data out (chains to the next element)
//   cfg_valid : full configuration loaded and not shifting
//   in        : K-bit LUT address
//   ce        : flip-flop clock enable
//   sr        : synchronous set/reset of the flip-flop to its init bit
//   lut_o     : raw combinational LUT value
//   X         : element output
// Modports: master drives the element (fabric / bench), slave is the element.
interface cfg_lut_ble_if #(
    parameter int K = 4
);
    logic         cfg_en;
    logic         cfg_in;
    logic         cfg_clr;
    logic         cfg_out;
    logic         cfg_valid;
    logic [K-1:0] in;
    logic         ce;
    logic         sr;
    logic         lut_o;
    logic         X;

    modport master (
        output cfg_en, cfg_in, cfg_clr, in, ce, sr,
        input  cfg_out, cfg_valid, lut_o, X
    );

    modport slave (
        input  cfg_en, cfg_in, cfg_clr, in, ce, sr,
        output cfg_out, cfg_valid, lut_o, X
    );
endinterface

// File: rtl/ble_cfg_chain.sv
// ble_cfg_chain -- serial configuration chain of one basic logic element.
//
// Shifts cfg_in into the LSB of the config register while cfg_en is high,
// counts the loaded bits (saturating at CFG_W) and reports when a complete
// configuration is present and the chain is idle.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   cfg_en     : shift enable
//   cfg_in     : serial data in
//   cfg_clr    : synchronous clear (wins over cfg_en)
//   cfg_reg    : parallel view of the config register
//   cfg_out    : MSB of the config register (to the next element)
//   cfg_valid  : count == CFG_W and not shifting
module ble_cfg_chain
    import ble_pkg::*;
#(
    parameter int K = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_en,
    input  logic                    cfg_in,
    input  logic                    cfg_clr,
    output logic [cfg_width(K)-1:0] cfg_reg,
    output logic                    cfg_out,
    output logic                    cfg_valid
);
    localparam int CFG_W = cfg_width(K);
    localparam int CNT_W = $clog2(CFG_W + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);

    logic [CFG_W-1:0] cfg_reg_p1;
    logic [CNT_W-1:0] count_p1;

    // Stage p1: config shift register and loaded-bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg_p1 <= '0;
            count_p1   <= '0;
        end else if (cfg_clr) begin
            cfg_reg_p1 <= '0;
            count_p1   <= '0;
        end else if (cfg_en) begin
            cfg_reg_p1 <= {cfg_reg_p1[CFG_W-2:0], cfg_in};
            // Overshifting keeps moving data downstream but the count sticks,
            // so a chain of elements still reports valid once fully loaded.
            if (count_p1 != CNT_FULL) begin
                count_p1 <= count_p1 + 1'b1;
            end
        end
    end

    assign cfg_reg   = cfg_reg_p1;
    assign cfg_out   = cfg_reg_p1[CFG_W-1];
    // Valid drops in any shifting cycle: the contents are in motion.
    assign cfg_valid = (count_p1 == CNT_FULL) && !cfg_en;

endmodule

// File: rtl/cfg_lut_ble.sv
// cfg_lut_ble -- K-input basic logic element: serially configured LUT plus an
// optional output flip-flop with clock enable and synchronous set/reset.
//
// Config register layout (shifted in MSB first: mode, init, tt[2**K-1] .. tt[0]):
//   cfg_reg[CFG_W-1]    mode (1 = registered output)
//   cfg_reg[CFG_W-2]    init value loaded into the FF by sr
//   cfg_reg[2**K-1:0]   truth table, tt[i] is the output for in == i
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset (config, counter and FF cleared)
//   bus   : cfg_lut_ble_if slave modport (config chain, LUT inputs, ce, sr,
//           lut_o, X)
// K is legal in 2..6; the interface instance must use the same K.
module cfg_lut_ble
    import ble_pkg::*;
#(
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    cfg_lut_ble_if.slave bus
);
    localparam int CFG_W    = cfg_width(K);
    localparam int NTT      = 1 << K;
    localparam int MODE_BIT = mode_ofs(K);
    localparam int INIT_BIT = init_ofs(K);

    logic [CFG_W-1:0] cfg_reg;
    logic             cfg_valid;
    logic             cfg_out;
    logic [NTT-1:0]   tt;
    logic             init_bit;
    out_mode_e        mode;
    logic             lut_p0;
    logic             q_p1;

    ble_cfg_chain #(
        .K (K)
    ) u_chain (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_en    (bus.cfg_en),
        .cfg_in    (bus.cfg_in),
        .cfg_clr   (bus.cfg_clr),
        .cfg_reg   (cfg_reg),
        .cfg_out   (cfg_out),
        .cfg_valid (cfg_valid)
    );

    assign tt       = cfg_reg[TT_LSB +: NTT];
    assign init_bit = cfg_reg[INIT_BIT];
    assign mode     = out_mode_e'(cfg_reg[MODE_BIT]);

    // Stage p0: LUT lookup, fully decoded from the address inputs
    assign lut_p0 = tt[bus.in];

    // Stage p1: output flip-flop, frozen until a complete configuration exists
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_p1 <= 1'b0;
        end else if (cfg_valid) begin
            if (bus.sr) begin
                q_p1 <= init_bit;
            end else if (bus.ce) begin
                q_p1 <= lut_p0;
            end
        end
    end

    assign bus.cfg_out   = cfg_out;
    assign bus.cfg_valid = cfg_valid;
    assign bus.lut_o     = lut_p0;
    assign bus.X         = cfg_valid && ((mode == REG) ? q_p1 : lut_p0);

endmodule

// File: tb/tb_cfg_lut_ble.sv
// tb_cfg_lut_ble -- self-checking bench for cfg_lut_ble with K = 4.
// The reference model keeps the configuration as "the last CFG_W bits shifted
// since the last clear/reset" plus a single FF value, and derives every output
// from that; a forked process compares all outputs on each falling edge.
module tb_cfg_lut_ble;
    localparam int K     = 4;
    localparam int NTT   = 1 << K;
    localparam int CFG_W = NTT + 2;

    logic clk;
    logic rst_n;

    cfg_lut_ble_if #(.K(K)) bus ();

    cfg_lut_ble #(.K(K)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    bit chk_on;

    // Reference model state
    bit hist[$];
    bit m_q;

    function automatic bit m_bit(input int j);
        int n;
        n = hist.size();
        if (j < n) return hist[n-1-j];
        return 1'b0;
    endfunction

    function automatic bit m_valid();
        return (hist.size() == CFG_W) && !bus.cfg_en;
    endfunction

    function automatic bit m_lut();
        return m_bit(int'(bus.in));
    endfunction

    function automatic bit m_x();
        if (!m_valid()) return 1'b0;
        return m_bit(CFG_W-1) ? m_q : m_lut();
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic compare_all();
        chk("model cfg_out",   bus.cfg_out,   m_bit(CFG_W-1));
        chk("model cfg_valid", bus.cfg_valid, m_valid());
        chk("model lut_o",     bus.lut_o,     m_lut());
        chk("model X",         bus.X,         m_x());
    endtask

    // One clock edge: model state advances with the inputs seen before the edge.
    task automatic tick();
        bit v, l, ini;
        v   = m_valid();
        l   = m_lut();
        ini = m_bit(CFG_W-2);
        @(posedge clk);
        if (rst_n) begin
            if (bus.cfg_clr) begin
                hist.delete();
            end else if (bus.cfg_en) begin
                hist.push_back(bus.cfg_in);
                if (hist.size() > CFG_W) void'(hist.pop_front());
            end
            if (v) begin
                if (bus.sr)      m_q = ini;
                else if (bus.ce) m_q = l;
            end
        end
        #1;
    endtask

    task automatic shift(input bit b);
        bus.cfg_en = 1'b1;
        bus.cfg_in = b;
        tick();
    endtask

    task automatic clear_cfg();
        bus.cfg_clr = 1'b1;
        tick();
        bus.cfg_clr = 1'b0;
    endtask

    task automatic load(input bit mode, input bit init, input logic [NTT-1:0] tt);
        clear_cfg();
        shift(mode);
        shift(init);
        for (int i = NTT-1; i >= 0; i--) shift(tt[i]);
        bus.cfg_en = 1'b0;
        bus.cfg_in = 1'b0;
        #1;
    endtask

    task automatic set_in(input int v);
        bus.in = 4'(v);
        #1;
    endtask

    initial begin
        logic [NTT-1:0] xor4;
        checks = 0;
        errors = 0;
        chk_on = 1'b0;
        m_q    = 1'b0;
        xor4   = 16'h6996;
        rst_n       = 1'b0;
        bus.cfg_en  = 1'b0;
        bus.cfg_in  = 1'b0;
        bus.cfg_clr = 1'b0;
        bus.in      = '0;
        bus.ce      = 1'b0;
        bus.sr      = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (chk_on) compare_all();
            end
        join_none

        // Reset state
        #1;
        chk("reset cfg_out",   bus.cfg_out,   1'b0);
        chk("reset cfg_valid", bus.cfg_valid, 1'b0);
        chk("reset lut_o",     bus.lut_o,     1'b0);
        chk("reset X",         bus.X,         1'b0);
        chk_on = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: XOR4 combinational, valid only after the 18th bit with cfg_en low
        clear_cfg();
        shift(1'b0);
        shift(1'b0);
        for (int i = NTT-1; i >= 1; i--) shift(xor4[i]);
        bus.cfg_en = 1'b0;
        #1;
        chk("valid after 17", bus.cfg_valid, 1'b0);
        shift(xor4[0]);
        bus.cfg_en = 1'b0;
        #1;
        chk("valid after 18", bus.cfg_valid, 1'b1);
        for (int i = 0; i < NTT; i++) begin
            set_in(i);
            chk("xor4 sweep", bus.X, ^(4'(i)));
            tick();
        end
        set_in(4'b0011);
        chk("xor4 in=0011", bus.X, 1'b0);
        set_in(4'b0111);
        chk("xor4 in=0111", bus.X, 1'b1);
        tick();

        // 2: XOR4 registered
        load(1'b1, 1'b0, xor4);
        bus.ce = 1'b1;
        set_in(0);
        tick();
        set_in(1);
        chk("reg same cycle", bus.X, 1'b0);
        tick();
        chk("reg next edge", bus.X, 1'b1);
        bus.ce = 1'b0;
        set_in(3);
        tick();
        chk("reg hold ce=0 a", bus.X, 1'b1);
        set_in(0);
        tick();
        chk("reg hold ce=0 b", bus.X, 1'b1);

        // 3: AND4 registered with init=1, sr beats ce
        load(1'b1, 1'b1, 16'h8000);
        bus.ce = 1'b1;
        bus.sr = 1'b1;
        set_in(0);
        tick();
        chk("sr loads init", bus.X, 1'b1);
        bus.sr = 1'b0;
        tick();
        chk("ce after sr", bus.X, 1'b0);
        set_in(15);
        chk("and4 lut_o", bus.lut_o, 1'b1);
        tick();
        chk("and4 reg", bus.X, 1'b1);
        bus.ce = 1'b0;
        set_in(0);

        // 4: chain pass-through, a 1 reaches cfg_out after 18 shifts
        clear_cfg();
        for (int k = 1; k <= 2*CFG_W; k++) begin
            shift(k == 1);
            chk("chain cfg_out", bus.cfg_out, k == CFG_W);
            chk("chain valid low", bus.cfg_valid, 1'b0);
        end
        bus.cfg_en = 1'b0;
        bus.cfg_in = 1'b0;
        #1;
        chk("chain valid high", bus.cfg_valid, 1'b1);
        chk("chain X zero tt", bus.X, 1'b0);
        tick();

        // 5: asynchronous reset mid-load, then full reload
        clear_cfg();
        for (int k = 0; k < 10; k++) shift(1'b1);
        bus.cfg_en = 1'b0;
        set_in(0);
        chk("partial lut_o", bus.lut_o, 1'b1);
        #1;
        rst_n = 1'b0;
        hist.delete();
        m_q = 1'b0;
        #1;
        chk("async rst X",         bus.X,         1'b0);
        chk("async rst cfg_out",   bus.cfg_out,   1'b0);
        chk("async rst cfg_valid", bus.cfg_valid, 1'b0);
        chk("async rst lut_o",     bus.lut_o,     1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        load(1'b0, 1'b0, xor4);
        set_in(4'b1011);
        chk("reload xor4 1011", bus.X, 1'b1);
        set_in(4'b1001);
        chk("reload xor4 1001", bus.X, 1'b0);
        tick();

        // 6: cfg_clr wins over cfg_en
        set_in(1);
        chk("before clr X", bus.X, 1'b1);
        bus.cfg_clr = 1'b1;
        bus.cfg_en  = 1'b1;
        bus.cfg_in  = 1'b1;
        tick();
        bus.cfg_clr = 1'b0;
        bus.cfg_en  = 1'b0;
        bus.cfg_in  = 1'b0;
        #1;
        chk("clr cfg_valid", bus.cfg_valid, 1'b0);
        chk("clr X",         bus.X,         1'b0);
        chk("clr lut_o",     bus.lut_o,     1'b0);
        chk("clr cfg_out",   bus.cfg_out,   1'b0);
        tick();
        tick();

        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
